// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response handshakes between the MEM stage and the data memory
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: byte-array data memory answering one request at a time after LATENCY wait cycles
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dmem_responder_if.slave  bus,
  output logic             busy_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          write_q, write_d, err_q, err_d;
  logic [7:0]    mem_q [DEPTH];
  logic          in_idle, accept, access, misaligned, commit, acc_write;
  logic [AW-1:0] acc_addr, base;
  logic [31:0]   acc_wdata, load_data;
  logic [3:0]    acc_wstrb;
  logic          unused_addr;
  assign unused_addr   = ^bus.req_addr[31:AW];
  assign in_idle       = state_q == IDLE;
  assign bus.req_ready = rst_ni && in_idle;
  assign accept        = bus.req_valid && bus.req_ready;
  // With zero latency the access happens on the accept edge, straight from the bus
  assign acc_addr   = in_idle ? bus.req_addr[AW-1:0] : addr_q;
  assign acc_write  = in_idle ? bus.req_write : write_q;
  assign acc_wdata  = in_idle ? bus.req_wdata : wdata_q;
  assign acc_wstrb  = in_idle ? bus.req_wstrb : wstrb_q;
  assign access     = (in_idle && accept && LATENCY == 0) || (state_q == WAIT && cnt_q == 4'd1);
  assign misaligned = acc_addr[1:0] != 2'b00;
  assign commit     = access && acc_write && !misaligned;
  assign base       = {acc_addr[AW-1:2], 2'b00};
  assign busy_o         = !in_idle;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  always_comb
    for (int i = 0; i < 4; i++) load_data[8*i +: 8] = mem_q[base | AW'(i)];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = bus.req_addr[AW-1:0];
        write_d = bus.req_write;
        wdata_d = bus.req_wdata;
        wstrb_d = bus.req_wstrb;
        state_d = LATENCY == 0 ? RESP : WAIT;
        cnt_d   = 4'(LATENCY);
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? RESP : WAIT;
      end
      RESP: if (bus.resp_ready) begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (access) begin
      err_d   = misaligned;
      rdata_d = (misaligned || acc_write) ? '0 : load_data;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  // Storage is deliberately left out of reset
  always_ff @(posedge clk_i)
    for (int i = 0; i < 4; i++)
      if (commit && acc_wstrb[i]) mem_q[base | AW'(i)] <= acc_wdata[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of the wait-state responder at LATENCY=2 and LATENCY=0
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy2, busy0;
  int checks = 0;
  int errors = 0;
  dmem_responder_if m();
  dmem_responder_if z();
  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(m), .busy_o(busy2));
  dmem_responder #(.DEPTH(1024), .LATENCY(0)) u_lat0 (.clk_i(clk), .rst_ni(rst_n), .bus(z), .busy_o(busy0));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    m.req_valid = 1'b1;
    m.req_write = w;
    m.req_addr  = a;
    m.req_wdata = d;
    m.req_wstrb = s;
    while (!m.req_ready && n < 20) begin tick(); n++; end
    checks++;
    if (m.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout req_ready=%b required 1", m.req_ready);
    end
    tick();
    m.req_valid = 1'b0;
    m.req_write = 'x;
    m.req_addr  = 'x;
    m.req_wdata = 'x;
    m.req_wstrb = 'x;
  endtask

  task automatic wait_resp(output logic [31:0] rd, output logic e, output int lat);
    lat = 0;
    while (!m.resp_valid && lat < 20) begin tick(); lat++; end
    rd = m.resp_rdata;
    e  = m.resp_err;
  endtask

  task automatic finish_resp();
    m.resp_ready = 1'b1;
    tick();
    m.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    {m.req_valid, m.req_write, m.resp_ready} = '0;
    {m.req_addr, m.req_wdata, m.req_wstrb} = '0;
    {z.req_valid, z.req_write, z.resp_ready} = '0;
    {z.req_addr, z.req_wdata, z.req_wstrb} = '0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (m.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", m.req_ready); end
    checks++;
    if (m.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", m.resp_valid); end
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy2); end
    checks++;
    if (m.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", m.resp_rdata); end
    checks++;
    if (m.resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", m.resp_err); end
    checks++;
    if (z.req_ready !== 1'b1) begin errors++; $display("FAIL reset_lat0_req_ready got %b exp 1", z.req_ready); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic [7:0] lo;
    logic e;
    int lat;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    checks++;
    if ({m.resp_valid, busy2, m.req_ready} !== 3'b010) begin
      errors++;
      $display("FAIL store_wait_flags got v/busy/rdy=%b exp 010", {m.resp_valid, busy2, m.req_ready});
    end
    wait_resp(rd, e, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL store_latency got %0d exp 2", lat); end
    checks++;
    if ({rd, e} !== 33'h0) begin errors++; $display("FAIL store_resp got rdata=%h err=%b exp 0/0", rd, e); end
    finish_resp();
    checks++;
    if ({m.resp_valid, m.req_ready, busy2} !== 3'b010) begin
      errors++;
      $display("FAIL store_done_flags got v/rdy/busy=%b exp 010", {m.resp_valid, m.req_ready, busy2});
    end
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_resp(rd, e, lat);
    lo = rd[7:0];
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d exp 2", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", rd); end
    checks++;
    if (lo !== 8'hEF) begin errors++; $display("FAIL load_byte0 got %h exp ef", lo); end
    finish_resp();
    checks++;
    if (m.resp_rdata !== 32'h0) begin errors++; $display("FAIL load_rdata_clear got %h exp 0", m.resp_rdata); end
  endtask

  task automatic test_partial();
    logic [31:0] rd;
    logic e;
    int lat;
    issue(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF);
    wait_resp(rd, e, lat);
    finish_resp();
    issue(1'b1, 32'h20, 32'h11223344, 4'b0101);
    wait_resp(rd, e, lat);
    finish_resp();
    issue(1'b1, 32'h20, 32'h99999999, 4'b0000);
    wait_resp(rd, e, lat);
    checks++;
    if ({lat, e} !== {32'd2, 1'b0}) begin errors++; $display("FAIL nostrobe_resp got lat=%0d err=%b exp 2/0", lat, e); end
    finish_resp();
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    wait_resp(rd, e, lat);
    checks++;
    if (rd !== 32'hAA22AA44) begin errors++; $display("FAIL partial_rdata got %h exp aa22aa44", rd); end
    finish_resp();
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic e;
    int lat;
    issue(1'b0, 32'h13, 32'h0, 4'h0);
    wait_resp(rd, e, lat);
    checks++;
    if ({rd, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL misaligned_load got rdata=%h err=%b exp 0/1", rd, e); end
    finish_resp();
    checks++;
    if (m.resp_err !== 1'b0) begin errors++; $display("FAIL misaligned_err_clear got %b exp 0", m.resp_err); end
    issue(1'b1, 32'h11, 32'h00000000, 4'hF);
    wait_resp(rd, e, lat);
    checks++;
    if ({rd, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL misaligned_store got rdata=%h err=%b exp 0/1", rd, e); end
    finish_resp();
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_resp(rd, e, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_unchanged got %h exp deadbeef", rd); end
    finish_resp();
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic e;
    int lat;
    issue(1'b1, 32'h400, 32'h55667788, 4'hF);
    wait_resp(rd, e, lat);
    finish_resp();
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    wait_resp(rd, e, lat);
    checks++;
    if (rd !== 32'h55667788) begin errors++; $display("FAIL wrap_load0 got %h exp 55667788", rd); end
    finish_resp();
    issue(1'b0, 32'hFFFF_F410, 32'h0, 4'h0);
    wait_resp(rd, e, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_high_bits got %h exp deadbeef", rd); end
    finish_resp();
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic e;
    int lat;
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    wait_resp(rd, e, lat);
    m.req_valid = 1'b1;
    m.req_write = 1'b1;
    m.req_addr  = 32'h20;
    m.req_wdata = 32'h0;
    m.req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({m.resp_valid, m.req_ready, m.resp_rdata} !== {2'b10, 32'hAA22AA44}) begin
        errors++;
        $display("FAIL stall_cycle%0d got v=%b rdy=%b rdata=%h exp 1/0/aa22aa44", i, m.resp_valid, m.req_ready, m.resp_rdata);
      end
    end
    finish_resp();
    m.req_valid = 1'b0;
    checks++;
    if ({m.resp_valid, m.req_ready, busy2} !== 3'b010) begin
      errors++;
      $display("FAIL stall_release got v/rdy/busy=%b exp 010", {m.resp_valid, m.req_ready, busy2});
    end
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    wait_resp(rd, e, lat);
    checks++;
    if (rd !== 32'hAA22AA44) begin errors++; $display("FAIL stall_no_accept got %h exp aa22aa44", rd); end
    finish_resp();
  endtask

  task automatic test_latency0();
    z.req_valid = 1'b1;
    z.req_write = 1'b1;
    z.req_addr  = 32'h8;
    z.req_wdata = 32'h0BADCAFE;
    z.req_wstrb = 4'hF;
    tick();
    z.req_valid = 1'b0;
    checks++;
    if ({z.resp_valid, busy0, z.resp_rdata} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL lat0_store got v=%b busy=%b rdata=%h exp 1/1/0", z.resp_valid, busy0, z.resp_rdata);
    end
    z.resp_ready = 1'b1;
    tick();
    z.resp_ready = 1'b0;
    checks++;
    if ({z.resp_valid, z.req_ready} !== 2'b01) begin errors++; $display("FAIL lat0_done got v/rdy=%b exp 01", {z.resp_valid, z.req_ready}); end
    z.req_valid = 1'b1;
    z.req_write = 1'b0;
    tick();
    z.req_valid = 1'b0;
    checks++;
    if ({z.resp_valid, z.resp_rdata} !== {1'b1, 32'h0BADCAFE}) begin
      errors++;
      $display("FAIL lat0_load got v=%b rdata=%h exp 1/0badcafe", z.resp_valid, z.resp_rdata);
    end
    z.resp_ready = 1'b1;
    tick();
    z.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic e;
    int lat;
    issue(1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    wait_resp(rd, e, lat);
    finish_resp();
    issue(1'b1, 32'h40, 32'h12345678, 4'hF);
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b exp 1", busy2); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy2, m.resp_valid, m.resp_rdata, m.resp_err} !== 35'h0) begin
      errors++;
      $display("FAIL midreset_outputs got busy=%b v=%b rdata=%h err=%b exp all 0", busy2, m.resp_valid, m.resp_rdata, m.resp_err);
    end
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({m.req_ready, busy2} !== 2'b10) begin errors++; $display("FAIL midreset_release got rdy/busy=%b exp 10", {m.req_ready, busy2}); end
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    wait_resp(rd, e, lat);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL midreset_not_committed got %h exp cafef00d", rd); end
    finish_resp();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial();
    test_misaligned();
    test_wrap();
    test_backpressure();
    test_latency0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
